lenet_job_sequencer: RTL
========================

// Module: lenet_job_sequencer
// PURPOSE
//  Avalon-MM slave that queues LeNet classification jobs (5-bit graph ids) and runs them one at a time on lenet_top.
//  For each job it pulses the accelerator reset, issues start, waits for finish and captures max_index into a result FIFO.
//  Sits between the NIOS II bus and lenet_top. It replaces direct software poking of the graph/start registers.
// PARAMETERS
//  CMD_DEPTH      8        command FIFO entries (power of 2)
//  RES_DEPTH      8        result FIFO entries (power of 2)
//  RST_CYCLES     4        cycles acc_rst is held high before each start (>=1)
//  TIMEOUT_CYCLES 1048576  run watchdog limit; used only with LENET_SEQ_TIMEOUT_EN
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   asynchronous, active-low reset
//  address        in   2   Avalon word address
//  chipselect     in   1   Avalon select
//  write          in   1   Avalon write strobe
//  read           in   1   Avalon read strobe
//  writedata      in   32  Avalon write data
//  readdata       out  32  Avalon read data, registered, read latency 1
//  acc_rst        out  1   active-high reset to lenet_top
//  acc_start      out  1   start level to lenet_top
//  acc_graph      out  5   graph id of the running job
//  acc_done       in   1   lenet_top finish flag
//  acc_max_index  in   4   classification result, valid while acc_done=1
//  disp_index     out  4   last captured max_index, for x7seg_scan
// BEHAVIOUR
//  Reset values: readdata=0, acc_rst=1, acc_start=0, acc_graph=0, disp_index=0. Both FIFOs empty, enable=0, sticky flags=0.
//  Register map:
//   0 W: CMD. Pushes writedata[4:0]. If the FIFO is full the write is dropped and sticky ovf is set.
//   1 R: RESULT. Returns {valid[31], err[16], graph[12:8], max_index[3:0]} and pops 1 entry.
//        When empty it returns 0 with valid=0 and does not pop.
//   2 R: STATUS = {res_cnt[23:16], cmd_cnt[15:8], tmo[3], ovf[2], busy[1], enable[0]}.
//   2 W: write-1-to-clear on bits 3:2.
//   3 W: CTRL. bit0 sets enable (level). bit1 is flush (self-clearing).
//  FSM: IDLE -> ARST -> START -> RUN -> CAPT -> IDLE.
//   IDLE: acc_rst=1, acc_start=0. Moves to ARST when enable && cmd not empty && result FIFO not full.
//         On that transition it pops the command and latches it into acc_graph.
//   ARST: acc_rst=1 for RST_CYCLES cycles (counter), then moves to START.
//   START: acc_rst=0, acc_start=1, 1 cycle, then RUN. acc_start stays 1 through RUN, matching lenet_top's level-start usage.
//   RUN: waits for acc_done=1 and samples acc_max_index in the same cycle.
//   CAPT: pushes {err=0, acc_graph, idx} to the result FIFO, updates disp_index, drops acc_start, raises acc_rst. 1 cycle, then IDLE.
//  busy=1 in every state except IDLE. Minimum job length is RST_CYCLES+3 cycles plus accelerator time.
//  Result FIFO space is checked before launch, so CAPT never overflows.
//  Same-cycle CMD push and FSM pop are both honoured, so the count is unchanged. The same holds for RESULT read and CAPT push.
//  Clearing enable mid-job: the current job completes and no new job launches.
//  Flush: empties both FIFOs and aborts any job. FSM returns to IDLE next cycle with acc_rst=1, acc_start=0, and no result is pushed.
//   A CMD write in the same cycle as flush is discarded.
//  Writes to unmapped bits are ignored. Reads of addresses 0 and 3 return 0.
//  reset_n is asserted asynchronously at any time, including mid-job, and restores all reset values.
// CONFIGURATION
//  LENET_SEQ_TIMEOUT_EN defined: RUN counts cycles.
//   On reaching TIMEOUT_CYCLES without acc_done, CAPT pushes {err=1, graph, max_index=4'hF}, sets sticky tmo, and disp_index=4'hF.
//  Not defined: RUN waits indefinitely, tmo reads 0, err is always 0, and no timeout counter is synthesized.
// STRUCTURE
//  lenet_seq_pkg holds:
//   state_t enum {IDLE,ARST,START,RUN,CAPT};
//   register address constants REG_CMD=0, REG_RESULT=1, REG_STATUS=2, REG_CTRL=3;
//   res_entry_t packed struct {err, graph[4:0], max_index[3:0]}.
//  Sub-module lenet_seq_fifo is a parameterised (WIDTH, DEPTH) sync FIFO with count/full/empty.
//   It is instantiated twice, for commands (5b) and results (10b).
// TESTING
//  1. Push CMD 3, write CTRL=1, model done after 20 cycles with idx 7.
//     Expect acc_rst high 4 cycles, a 1-cycle start, RESULT read = 0x8000_0307, disp_index=7.
//  2. Push 9 CMDs with enable=0. STATUS reads cmd_cnt=8 and ovf=1. Write STATUS 0x4 and ovf clears.
//  3. Queue 10 jobs with no RESULT reads. Exactly 8 results are captured, then the FSM stays in IDLE with cmd_cnt=2.
//     One RESULT read lets exactly 1 more job launch.
//  4. Flush during RUN. Next cycle acc_start=0, acc_rst=1, cmd_cnt=0, res_cnt=0, and a later acc_done is ignored.
//  5. With LENET_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, never assert done.
//     After 100 RUN cycles RESULT = 0x8001_xx0F (xx = graph id << 8) and tmo=1.
//  6. Assert reset_n low mid-RUN. All outputs return to reset values asynchronously and the FIFOs are empty after release.

Source files
------------

// File: rtl/lenet_seq_pkg.sv
// Shared types and constants for the LeNet job sequencer.
package lenet_seq_pkg;

    typedef enum logic [2:0] {IDLE, ARST, START, RUN, CAPT} state_t;

    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_RESULT = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef struct packed {
        logic       err;
        logic [4:0] graph;
        logic [3:0] max_index;
    } res_entry_t;

    // RESULT register layout; an empty FIFO reads as all zeros.
    function automatic logic [31:0] result_word(input logic valid, input res_entry_t e);
        return valid ? {1'b1, 14'b0, e.err, 3'b0, e.graph, 4'b0, e.max_index} : 32'b0;
    endfunction

endpackage

// File: rtl/lenet_job_sequencer_if.sv
// Avalon-MM slave bus between the NIOS II and the job sequencer.
interface lenet_job_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write, read, writedata, input readdata);
    modport slave  (input address, chipselect, write, read, writedata, output readdata);
endinterface

// File: rtl/lenet_seq_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module lenet_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/lenet_job_sequencer.sv
// Queues LeNet graph ids and runs them one at a time on lenet_top.
// Optional run watchdog: define LENET_SEQ_TIMEOUT_EN.
module lenet_job_sequencer
    import lenet_seq_pkg::*;
#(
    parameter int CMD_DEPTH      = 8,
    parameter int RES_DEPTH      = 8,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  reset_n,
    lenet_job_sequencer_if.slave  bus,
    output logic                  acc_rst,
    output logic                  acc_start,
    output logic [4:0]            acc_graph,
    input  logic                  acc_done,
    input  logic [3:0]            acc_max_index,
    output logic [3:0]            disp_index
);
    localparam int RC_W = $clog2(RST_CYCLES + 1);

    if (RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("lenet_job_sequencer: RST_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_t            state, state_nxt;
    logic [RC_W-1:0]   rst_cnt;
    logic              enable, ovf, tmo, run_tmo;
    logic              cap_err;
    logic [3:0]        cap_idx;

    logic wr, rd, cmd_wr, stat_wr, ctrl_wr, res_rd, flush, launch;
    assign wr      = bus.chipselect && bus.write;
    assign rd      = bus.chipselect && bus.read;
    assign cmd_wr  = wr && bus.address == REG_CMD;
    assign stat_wr = wr && bus.address == REG_STATUS;
    assign ctrl_wr = wr && bus.address == REG_CTRL;
    assign res_rd  = rd && bus.address == REG_RESULT;
    assign flush   = ctrl_wr && bus.writedata[1];

    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:5];

    logic [4:0]                 cmd_dout;
    logic [$clog2(CMD_DEPTH):0] cmd_cnt;
    logic                       cmd_full, cmd_empty;
    res_entry_t                 res_din, res_dout;
    logic [$clog2(RES_DEPTH):0] res_cnt;
    logic                       res_full, res_empty;

    // Result space is reserved at launch so CAPT can always push.
    assign launch  = state == IDLE && enable && !cmd_empty && !res_full;
    assign res_din = '{err: cap_err, graph: acc_graph, max_index: cap_idx};

    lenet_seq_fifo #(.WIDTH(5), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk, .reset_n, .clear(flush),
        .push(cmd_wr && !flush), .din(bus.writedata[4:0]),
        .pop(launch), .dout(cmd_dout),
        .count(cmd_cnt), .full(cmd_full), .empty(cmd_empty)
    );

    lenet_seq_fifo #(.WIDTH($bits(res_entry_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk, .reset_n, .clear(flush),
        .push(state == CAPT && !flush), .din(res_din),
        .pop(res_rd), .dout(res_dout),
        .count(res_cnt), .full(res_full), .empty(res_empty)
    );

`ifdef LENET_SEQ_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0] tmo_cnt;

    assign run_tmo = state == RUN && !acc_done && tmo_cnt == TC_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            tmo     <= 1'b0;
        end else begin
            tmo_cnt <= (state == RUN) ? tmo_cnt + 1'b1 : '0;
            if (stat_wr && bus.writedata[3]) tmo <= 1'b0;
            if (state == CAPT && cap_err && !flush) tmo <= 1'b1;
        end
    end
`else
    assign run_tmo = 1'b0;
    assign tmo     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_rst   = 1'b1;
        acc_start = 1'b0;
        case (state)
            IDLE:  if (launch) state_nxt = ARST;
            ARST:  if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nxt = START;
            START: begin
                acc_rst   = 1'b0;
                acc_start = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                acc_rst   = 1'b0;
                acc_start = 1'b1;
                if (acc_done || run_tmo) state_nxt = CAPT;
            end
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt      <= '0;
            acc_graph    <= '0;
            cap_idx      <= '0;
            cap_err      <= 1'b0;
            disp_index   <= '0;
            enable       <= 1'b0;
            ovf          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            rst_cnt <= (state == ARST) ? rst_cnt + 1'b1 : '0;
            if (launch && !flush) acc_graph <= cmd_dout;
            if (state == RUN) begin
                cap_idx <= run_tmo ? 4'hF : acc_max_index;
                cap_err <= run_tmo;
            end
            if (state == CAPT && !flush) disp_index <= cap_idx;
            if (ctrl_wr) enable <= bus.writedata[0];
            if (stat_wr && bus.writedata[2]) ovf <= 1'b0;
            if (cmd_wr && cmd_full && !launch) ovf <= 1'b1;

            bus.readdata <= '0;
            if (rd) begin
                case (bus.address)
                    REG_RESULT: bus.readdata <= result_word(!res_empty, res_dout);
                    REG_STATUS: bus.readdata <= {8'b0, 8'(res_cnt), 8'(cmd_cnt), 4'b0,
                                                 tmo, ovf, state != IDLE, enable};
                    default:    bus.readdata <= '0;
                endcase
            end
        end
    end
endmodule
